// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem -- WIDTH x DEPTH storage array for sync_fifo_flex.
//
// One synchronous write port and one asynchronous (combinational) read port.
// The array has no reset: contents are undefined until written.
//
// Ports:
//   clk_i    : write clock (rising edge)
//   we_i     : write enable; stores wdata_i at waddr_i
//   waddr_i  : write address
//   wdata_i  : write data
//   raddr_i  : read address
//   rdata_o  : data at raddr_i (combinational)
module sync_fifo_mem #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/sync_fifo_flex.sv
// sync_fifo_flex -- single-clock FIFO with selectable read mode.
//
// FWFT=0: rdata_o is registered and updates one cycle after an accepted read,
//         holding its value otherwise.
// FWFT=1: rdata_o shows the head word combinationally whenever empty_o=0;
//         rd_en_i acknowledges (pops) the displayed word.
// Occupancy is held in an explicit counter; all flags decode from it.
//
// Ports:
//   clk_i          : clock, all state changes on rising edge
//   rst_i          : synchronous active-high reset
//   wdata_i        : write data
//   wr_en_i        : write request
//   rd_en_i        : read request / FWFT acknowledge
//   rdata_o        : read data
//   full_o         : count == DEPTH
//   empty_o        : count == 0
//   almost_full_o  : count >= AF_LEVEL
//   almost_empty_o : count <= AE_LEVEL
//   count_o        : occupancy 0..DEPTH
//   wr_error_o     : one-cycle pulse after a rejected write
//   rd_error_o     : one-cycle pulse after a rejected read
module sync_fifo_flex #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned FWFT     = 0,
  parameter int unsigned AF_LEVEL = DEPTH - 2,
  parameter int unsigned AE_LEVEL = 2,
  localparam int unsigned PTR_WIDTH = $clog2(DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [WIDTH-1:0]     wdata_i,
  input  logic                 wr_en_i,
  input  logic                 rd_en_i,
  output logic [WIDTH-1:0]     rdata_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic                 almost_full_o,
  output logic                 almost_empty_o,
  output logic [PTR_WIDTH:0]   count_o,
  output logic                 wr_error_o,
  output logic                 rd_error_o
);

  localparam int unsigned CNT_W = PTR_WIDTH + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT    = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_CNT    = CNT_W'(AE_LEVEL);

  logic [PTR_WIDTH-1:0] wr_ptr_q;
  logic [PTR_WIDTH-1:0] rd_ptr_q;
  logic [CNT_W-1:0]     count_q;
  logic [CNT_W-1:0]     count_d;
  logic                 wr_err_q;
  logic                 rd_err_q;
  logic                 full;
  logic                 empty;
  logic                 wr_acc;
  logic                 rd_acc;
  logic [WIDTH-1:0]     mem_rdata;

  // Flags come from the registered count only, so they are glitch-free
  // and valid in the cycle after the edge that changed the count.
  assign full  = (count_q == DEPTH_CNT);
  assign empty = (count_q == '0);

  // Acceptance is qualified by the current flags, which makes the
  // full+both and empty+both cases fall out naturally: the blocked side
  // is rejected while the other side proceeds.
  assign wr_acc = wr_en_i && !full;
  assign rd_acc = rd_en_i && !empty;

  always_comb begin
    count_d = count_q;
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointers are exactly PTR_WIDTH bits and DEPTH is a power of two, so the
  // DEPTH-1 -> 0 wrap is the natural binary rollover.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      wr_err_q <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q  <= count_d;
      wr_err_q <= wr_en_i && full;
      rd_err_q <= rd_en_i && empty;
    end
  end

  // The write is additionally gated by rst_i so a write requested in a
  // reset cycle never reaches the array.
  sync_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PTR_WIDTH)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (wr_acc && !rst_i),
    .waddr_i (wr_ptr_q),
    .wdata_i (wdata_i),
    .raddr_i (rd_ptr_q),
    .rdata_o (mem_rdata)
  );

  generate
    if (FWFT == 0) begin : g_reg_read
      logic [WIDTH-1:0] rdata_q;

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          rdata_q <= '0;
        end else if (rd_acc) begin
          rdata_q <= mem_rdata;
        end
      end

      assign rdata_o = rdata_q;
    end else begin : g_fwft
      // Head word is only meaningful when not empty; forcing zero while
      // empty keeps the output defined out of reset.
      assign rdata_o = empty ? '0 : mem_rdata;
    end
  endgenerate

  assign full_o         = full;
  assign empty_o        = empty;
  assign almost_full_o  = (count_q >= AF_CNT);
  assign almost_empty_o = (count_q <= AE_CNT);
  assign count_o        = count_q;
  assign wr_error_o     = wr_err_q;
  assign rd_error_o     = rd_err_q;

endmodule

// File: tb/tb_sync_fifo_flex.sv
module tb_sync_fifo_flex;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Instance A: defaults, registered read, DEPTH 16
  logic       rst_a = 1'b1;
  logic [7:0] wdata_a = '0;
  logic       wr_a = 1'b0;
  logic       rd_a = 1'b0;
  logic [7:0] rdata_a;
  logic       full_a, empty_a, af_a, ae_a, werr_a, rerr_a;
  logic [4:0] count_a;

  // Instance B: FWFT, DEPTH 4
  logic       rst_b = 1'b1;
  logic [7:0] wdata_b = '0;
  logic       wr_b = 1'b0;
  logic       rd_b = 1'b0;
  logic [7:0] rdata_b;
  logic       full_b, empty_b, af_b, ae_b, werr_b, rerr_b;
  logic [2:0] count_b;

  int unsigned checks = 0;
  int unsigned errors = 0;

  sync_fifo_flex #(
    .WIDTH    (8),
    .DEPTH    (16),
    .FWFT     (0),
    .AF_LEVEL (14),
    .AE_LEVEL (2)
  ) dut_a (
    .clk_i          (clk_i),
    .rst_i          (rst_a),
    .wdata_i        (wdata_a),
    .wr_en_i        (wr_a),
    .rd_en_i        (rd_a),
    .rdata_o        (rdata_a),
    .full_o         (full_a),
    .empty_o        (empty_a),
    .almost_full_o  (af_a),
    .almost_empty_o (ae_a),
    .count_o        (count_a),
    .wr_error_o     (werr_a),
    .rd_error_o     (rerr_a)
  );

  sync_fifo_flex #(
    .WIDTH    (8),
    .DEPTH    (4),
    .FWFT     (1),
    .AF_LEVEL (3),
    .AE_LEVEL (1)
  ) dut_b (
    .clk_i          (clk_i),
    .rst_i          (rst_b),
    .wdata_i        (wdata_b),
    .wr_en_i        (wr_b),
    .rd_en_i        (rd_b),
    .rdata_o        (rdata_b),
    .full_o         (full_b),
    .empty_o        (empty_b),
    .almost_full_o  (af_b),
    .almost_empty_o (ae_b),
    .count_o        (count_b),
    .wr_error_o     (werr_b),
    .rd_error_o     (rerr_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- reset both instances ----------------
    rst_a = 1'b1; rst_b = 1'b1; wr_a = 1'b1; rd_a = 1'b1;
    tick();
    tick();
    rst_a = 1'b0; rst_b = 1'b0; wr_a = 1'b0; rd_a = 1'b0;
    chk("a_rst_count", 32'(count_a), 0);
    chk("a_rst_empty", 32'(empty_a), 1);
    chk("a_rst_full",  32'(full_a), 0);
    chk("a_rst_ae",    32'(ae_a), 1);
    chk("a_rst_af",    32'(af_a), 0);
    chk("a_rst_rdata", 32'(rdata_a), 0);
    chk("a_rst_werr",  32'(werr_a), 0);
    chk("a_rst_rerr",  32'(rerr_a), 0);
    chk("b_rst_empty", 32'(empty_b), 1);
    chk("b_rst_rdata", 32'(rdata_b), 0);

    // ---------------- fill A with 0x01..0x10 ----------------
    for (int i = 1; i <= 16; i++) begin
      wdata_a = 8'(i); wr_a = 1'b1;
      tick();
      chk("a_fill_count", 32'(count_a), 32'(i));
      chk("a_fill_af",    32'(af_a),    (i >= 14) ? 32'd1 : 32'd0);
      chk("a_fill_ae",    32'(ae_a),    (i <= 2)  ? 32'd1 : 32'd0);
      chk("a_fill_full",  32'(full_a),  (i == 16) ? 32'd1 : 32'd0);
    end
    wdata_a = 8'h11;
    tick();
    chk("a_ovf_werr",  32'(werr_a), 1);
    chk("a_ovf_count", 32'(count_a), 16);
    wr_a = 1'b0;
    tick();
    chk("a_ovf_werr_clr", 32'(werr_a), 0);

    // ---------------- drain A ----------------
    for (int i = 1; i <= 16; i++) begin
      rd_a = 1'b1;
      tick();
      chk("a_drain_rdata", 32'(rdata_a), 32'(i));
      chk("a_drain_count", 32'(count_a), 32'(16 - i));
    end
    chk("a_drain_empty", 32'(empty_a), 1);
    tick();
    chk("a_udf_rerr",  32'(rerr_a), 1);
    chk("a_udf_rdata", 32'(rdata_a), 8'h10);
    rd_a = 1'b0;
    tick();
    chk("a_udf_rerr_clr", 32'(rerr_a), 0);

    // ---------------- steady state at count 8 ----------------
    for (int i = 0; i < 8; i++) begin
      wdata_a = 8'(8'h20 + i); wr_a = 1'b1;
      tick();
    end
    chk("a_ss_count0", 32'(count_a), 8);
    rd_a = 1'b1;
    for (int k = 0; k < 20; k++) begin
      wdata_a = 8'(8'h28 + k);
      tick();
      chk("a_ss_count", 32'(count_a), 8);
      chk("a_ss_rdata", 32'(rdata_a), 32'(8'h20 + k));
      chk("a_ss_errs",  32'({werr_a, rerr_a}), 0);
    end
    wr_a = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("a_ss_tail", 32'(rdata_a), 32'(8'h34 + k));
    end
    rd_a = 1'b0;
    chk("a_ss_empty", 32'(empty_a), 1);

    // ---------------- full + both, empty + both ----------------
    for (int i = 0; i < 16; i++) begin
      wdata_a = 8'(8'h40 + i); wr_a = 1'b1;
      tick();
    end
    wdata_a = 8'hEE; wr_a = 1'b1; rd_a = 1'b1;
    tick();
    chk("a_fb_count", 32'(count_a), 15);
    chk("a_fb_werr",  32'(werr_a), 1);
    chk("a_fb_rerr",  32'(rerr_a), 0);
    chk("a_fb_rdata", 32'(rdata_a), 8'h40);
    wr_a = 1'b0;
    for (int i = 1; i < 16; i++) begin
      tick();
      chk("a_fb_drain", 32'(rdata_a), 32'(8'h40 + i));
    end
    chk("a_fb_empty", 32'(empty_a), 1);
    wdata_a = 8'h77; wr_a = 1'b1; rd_a = 1'b1;
    tick();
    chk("a_eb_count", 32'(count_a), 1);
    chk("a_eb_rerr",  32'(rerr_a), 1);
    chk("a_eb_werr",  32'(werr_a), 0);
    chk("a_eb_rdata", 32'(rdata_a), 8'h4F);
    wr_a = 1'b0;
    tick();
    chk("a_eb_pop", 32'(rdata_a), 8'h77);
    chk("a_eb_count2", 32'(count_a), 0);
    rd_a = 1'b0;

    // ---------------- reset mid-operation ----------------
    for (int i = 0; i < 5; i++) begin
      wdata_a = 8'(8'h50 + i); wr_a = 1'b1;
      tick();
    end
    chk("a_mr_count5", 32'(count_a), 5);
    rst_a = 1'b1; wdata_a = 8'h99; wr_a = 1'b1;
    tick();
    chk("a_mr_count", 32'(count_a), 0);
    chk("a_mr_empty", 32'(empty_a), 1);
    chk("a_mr_rdata", 32'(rdata_a), 0);
    rst_a = 1'b0; wdata_a = 8'h33;
    tick();
    chk("a_mr_count1", 32'(count_a), 1);
    wr_a = 1'b0; rd_a = 1'b1;
    tick();
    chk("a_mr_rdata2", 32'(rdata_a), 8'h33);
    chk("a_mr_empty2", 32'(empty_a), 1);
    rd_a = 1'b0;

    // ---------------- FWFT instance ----------------
    wdata_b = 8'hA5; wr_b = 1'b1;
    tick();
    wr_b = 1'b0;
    chk("b_fw_empty", 32'(empty_b), 0);
    chk("b_fw_rdata", 32'(rdata_b), 8'hA5);
    tick();
    chk("b_fw_hold", 32'(rdata_b), 8'hA5);
    wdata_b = 8'h5A; wr_b = 1'b1;
    tick();
    wr_b = 1'b0;
    chk("b_fw_head", 32'(rdata_b), 8'hA5);
    chk("b_fw_count2", 32'(count_b), 2);
    rd_b = 1'b1;
    tick();
    chk("b_fw_pop", 32'(rdata_b), 8'h5A);
    chk("b_fw_count1", 32'(count_b), 1);
    tick();
    rd_b = 1'b0;
    chk("b_fw_empty2", 32'(empty_b), 1);
    for (int i = 1; i <= 4; i++) begin
      wdata_b = 8'(8'hC0 + i); wr_b = 1'b1;
      tick();
      chk("b_fill_af",   32'(af_b),   (i >= 3) ? 32'd1 : 32'd0);
      chk("b_fill_ae",   32'(ae_b),   (i <= 1) ? 32'd1 : 32'd0);
      chk("b_fill_full", 32'(full_b), (i == 4) ? 32'd1 : 32'd0);
    end
    wdata_b = 8'hFF;
    tick();
    wr_b = 1'b0;
    chk("b_ovf_werr",  32'(werr_b), 1);
    chk("b_ovf_count", 32'(count_b), 4);
    for (int i = 1; i <= 4; i++) begin
      chk("b_drain_head", 32'(rdata_b), 32'(8'hC0 + i));
      rd_b = 1'b1;
      tick();
    end
    rd_b = 1'b0;
    chk("b_drain_empty", 32'(empty_b), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo_flex.md
SYNC_FIFO_FLEX -- requirements
Module: sync_fifo_flex

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 16, number of entries; power of two, >=2.
REQ-003 SHALL have parameter FWFT, default 0, read mode: 0 = registered read, 1 = first-word-fall-through.
REQ-004 SHALL have parameter AF_LEVEL, default DEPTH-2, almost-full threshold in entries (1..DEPTH).
REQ-005 SHALL have parameter AE_LEVEL, default 2, almost-empty threshold in entries (0..DEPTH-1).
REQ-006 SHALL derive local constant PTR_WIDTH = $clog2(DEPTH).
REQ-007 SHALL have these ports (name  direction  width  meaning):
- clk_i  input  1  single clock; all state changes on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- wdata_i  input  WIDTH  write data.
- wr_en_i  input  1  write request.
- rd_en_i  input  1  read request (FWFT=1: acknowledge of displayed word).
- rdata_o  output  WIDTH  read data.
- full_o  output  1  count == DEPTH.
- empty_o  output  1  count == 0.
- almost_full_o  output  1  count >= AF_LEVEL.
- almost_empty_o  output  1  count <= AE_LEVEL.
- count_o  output  PTR_WIDTH+1  current occupancy, 0..DEPTH.
- wr_error_o  output  1  one-cycle pulse: write was rejected.
- rd_error_o  output  1  one-cycle pulse: read was rejected.

Function
REQ-008 SHALL accept a write iff wr_en_i=1 and full_o=0 at the rising edge; the word is stored at wr_ptr and wr_ptr advances by 1.
REQ-009 SHALL accept a read iff rd_en_i=1 and empty_o=0 at the rising edge; rd_ptr advances by 1.
REQ-010 SHALL wrap both pointers from DEPTH-1 to 0 with no other side effect; occupancy is tracked by count_o, not by toggle bits.
REQ-011 SHALL update count: +1 on write-only accept, -1 on read-only accept, unchanged on simultaneous accept or no accept.
REQ-012 SHALL, with full_o=1 and wr_en_i=rd_en_i=1, accept the read and reject the write (wr_error_o pulses); count goes DEPTH-1.
REQ-013 SHALL, with empty_o=1 and wr_en_i=rd_en_i=1, accept the write and reject the read (rd_error_o pulses); count goes 1.
REQ-014 SHALL drive full_o, empty_o, almost_full_o, almost_empty_o combinationally from registered count only (valid in the cycle after the edge that changed count).
REQ-015 FWFT=0: rdata_o SHALL present mem[rd_ptr] registered one cycle after an accepted read and hold its value otherwise.
REQ-016 FWFT=1: rdata_o SHALL continuously present mem[rd_ptr] (combinational read) and is valid whenever empty_o=0; an accepted read pops it and the next word appears the following cycle.
REQ-017 SHALL assert wr_error_o (resp. rd_error_o) for exactly one cycle after the edge at which a write (resp. read) was rejected, else 0.
REQ-018 SHALL never alter stored data or pointers on a rejected request.

Reset
REQ-019 SHALL, when rst_i=1 at a rising edge, set wr_ptr=0, rd_ptr=0, count_o=0, rdata_o=0, wr_error_o=0, rd_error_o=0, regardless of wr_en_i/rd_en_i.
REQ-020 SHALL give after reset: empty_o=1, full_o=0, almost_empty_o=1, almost_full_o=0.
REQ-021 SHALL not clear the memory array on reset; contents are don't-care until written.
REQ-022 SHALL discard all contents on reset asserted mid-operation; first post-reset read of a fresh write returns that write.

Structure
REQ-023 SHALL use no shared package; all constants are module parameters/localparams.
REQ-024 SHALL place storage in one sub-module sync_fifo_mem (1 write port, 1 async read port, WIDTH x DEPTH); pointer/count/flag logic stays in the top.

Verification
REQ-025 Reset then write 0x01..0x10 (DEPTH=16), FWFT=0 -> full_o=1 after 16th; almost_full_o=1 from count 14; 17th write -> wr_error_o pulses 1 cycle, count stays 16.
REQ-026 From full, 16 reads -> rdata_o sequence 0x01..0x10 each one cycle after its read; empty_o=1 after last; 17th read -> rd_error_o pulse, rdata_o holds 0x10.
REQ-027 Count 8, wr_en_i=rd_en_i=1 for 20 cycles with incrementing data -> count_o stays 8, pointers wrap, output order preserved, no error pulses.
REQ-028 FWFT=1: write 0xA5 -> next cycle empty_o=0, rdata_o=0xA5 with rd_en_i=0; write 0x5A then read -> rdata_o=0x5A following cycle.
REQ-029 Full FIFO, wr_en_i=rd_en_i=1 -> read accepted, wr_error_o pulses, count 15; empty FIFO, both -> write accepted, rd_error_o pulses, count 1.
REQ-030 Count 5, rst_i=1 with wr_en_i=1 -> count_o=0, empty_o=1, no write; then write 0x33, read -> 0x33.
